instruction_fetch_unit: RTL and testbench

Fetch-side counterpart to the jump/ALU control-word decoders. Owns the program counter and drives instruction memory through a request/ready handshake. Presents each fetched word to the decode stage with a valid/accept handshake. Consumes the decoded PC controls (`program_counter_increment`, PC load with ALU result) to choose the next fetch address.

---
 rtl/instruction_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Owns the program counter, reads instruction memory through a req/ready
// handshake and hands each fetched word to decode through a valid/accept
// handshake. The decoded PC controls presented at accept pick the next
// fetch address (load from ALU result, increment, or hold).
//
// Optional feature macro: IFU_MEM_TIMEOUT_EN
//   defined   : FETCH gives up after TIMEOUT_CYCLES cycles without mem_ready,
//               raises sticky fetch_error and parks in IDLE until reset.
//   undefined : no wait counter, fetch_error tied low, FETCH waits forever.
//
// Ports
//   clk                        rising-edge clock
//   reset_n                    asynchronous active-low reset
//   run                        fetch enable, sampled in IDLE and at accept
//   mem_req / mem_addr         memory read request and address (= PC)
//   mem_ready / mem_data       memory data valid strobe and instruction word
//   instruction                registered word for the decoder
//   instruction_valid          instruction holds an unconsumed word
//   exec_accept                decode consumes the word this cycle
//   program_counter_increment  decoded "PC + 1"
//   pc_load / pc_load_value    decoded "PC <- ALU result" and that result
//   program_counter            current PC
//   fetch_error                sticky memory timeout flag
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+------------------------------------------------------------------
// IDLE     | no request; waits for run (and no latched fetch_error)
// FETCH    | mem_req high at PC until mem_ready captures the word
// ISSUE    | word presented to decode; waits for exec_accept, then next PC
//
module instruction_fetch_unit #(
   parameter logic [15:0] RESET_PC       = 16'h0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        run,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ready,
   input  logic [15:0] mem_data,
   output logic [15:0] instruction,
   output logic        instruction_valid,
   input  logic        exec_accept,
   input  logic        program_counter_increment,
   input  logic        pc_load,
   input  logic [15:0] pc_load_value,
   output logic [15:0] program_counter,
   output logic        fetch_error
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] pc;
   logic [15:0] pc_nxt;
   logic [15:0] instr;
   logic [15:0] instr_nxt;
   logic        valid;
   logic        valid_nxt;
   logic        req_nxt;
   logic        timeout_hit;
   logic        error_flag;

`ifdef IFU_MEM_TIMEOUT_EN
   // Terminal count is one below the limit so the error lands on the edge
   // that ends the TIMEOUT_CYCLES-th wait cycle.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] wait_cnt;
   logic       err_q;

   assign timeout_hit = (state == ST_FETCH) && !mem_ready && (wait_cnt == TIMEOUT_LAST);
   assign error_flag  = err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= 8'd0;
         err_q    <= 1'b0;
      end else begin
         if ((state_nxt == ST_FETCH) && (state != ST_FETCH)) begin
            wait_cnt <= 8'd0;
         end else if ((state == ST_FETCH) && !mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (timeout_hit) begin
            err_q <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign error_flag  = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         pc      <= RESET_PC;
         instr   <= 16'h0000;
         valid   <= 1'b0;
         mem_req <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         instr   <= instr_nxt;
         valid   <= valid_nxt;
         mem_req <= req_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      instr_nxt = instr;
      valid_nxt = valid;
      unique case (state)
         ST_IDLE: begin
            if (run && !error_flag) begin
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            // run is not looked at here: a started fetch always completes.
            if (mem_ready) begin
               instr_nxt = mem_data;
               valid_nxt = 1'b1;
               state_nxt = ST_ISSUE;
            end else if (timeout_hit) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (exec_accept) begin
               if (pc_load) begin
                  pc_nxt = pc_load_value;
               end else if (program_counter_increment) begin
                  pc_nxt = pc + 16'd1;
               end
               valid_nxt = 1'b0;
               state_nxt = run ? ST_FETCH : ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      // Request is registered so it tracks the state being entered.
      req_nxt = (state_nxt == ST_FETCH);
   end

   assign mem_addr          = pc;
   assign program_counter   = pc;
   assign instruction       = instr;
   assign instruction_valid = valid;
   assign fetch_error       = error_flag;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

   localparam logic [15:0] RST_PC = 16'h0000;

   logic        clk;
   logic        reset_n;
   logic        run;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ready;
   logic [15:0] mem_data;
   logic [15:0] instruction;
   logic        instruction_valid;
   logic        exec_accept;
   logic        program_counter_increment;
   logic        pc_load;
   logic [15:0] pc_load_value;
   logic [15:0] program_counter;
   logic        fetch_error;

   int          tests_run = 0;
   int          tests_failed = 0;
   logic [15:0] exp_pc;

   instruction_fetch_unit #(
      .RESET_PC       (RST_PC),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk                       (clk),
      .reset_n                   (reset_n),
      .run                       (run),
      .mem_req                   (mem_req),
      .mem_addr                  (mem_addr),
      .mem_ready                 (mem_ready),
      .mem_data                  (mem_data),
      .instruction               (instruction),
      .instruction_valid         (instruction_valid),
      .exec_accept               (exec_accept),
      .program_counter_increment (program_counter_increment),
      .pc_load                   (pc_load),
      .pc_load_value             (pc_load_value),
      .program_counter           (program_counter),
      .fetch_error               (fetch_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Random values on inputs that must be ignored outside ISSUE.
   task automatic scramble_ignored();
      exec_accept               = 1'($urandom);
      pc_load                   = 1'($urandom);
      program_counter_increment = 1'($urandom);
      pc_load_value             = 16'($urandom);
   endtask

   // One full instruction transaction. Entered at a falling edge with the
   // DUT requesting at exp_pc; leaves it requesting at the next address.
   task automatic fetch_issue(input int ws, input logic [15:0] data, input int hold,
                              input logic ld, input logic [15:0] ld_val,
                              input logic inc, input logic run_after);
      for (int w = 0; w < ws; w++) begin
         mem_ready = 1'b0;
         mem_data  = 16'($urandom);
         run       = 1'($urandom);
         scramble_ignored();
         chk("wait_req", 16'(mem_req), 16'd1);
         chk("wait_addr", mem_addr, exp_pc);
         chk("wait_valid", 16'(instruction_valid), 16'd0);
         chk("wait_err", 16'(fetch_error), 16'd0);
         @(negedge clk);
      end
      mem_ready = 1'b1;
      mem_data  = data;
      scramble_ignored();
      chk("fetch_req", 16'(mem_req), 16'd1);
      chk("fetch_addr", mem_addr, exp_pc);
      @(negedge clk);
      mem_ready = 1'($urandom);
      mem_data  = 16'($urandom);
      for (int h = 0; h < hold; h++) begin
         exec_accept               = 1'b0;
         pc_load                   = 1'($urandom);
         program_counter_increment = 1'($urandom);
         pc_load_value             = 16'($urandom);
         run                       = 1'($urandom);
         chk("hold_valid", 16'(instruction_valid), 16'd1);
         chk("hold_instr", instruction, data);
         chk("hold_req", 16'(mem_req), 16'd0);
         chk("hold_pc", program_counter, exp_pc);
         @(negedge clk);
      end
      chk("issue_valid", 16'(instruction_valid), 16'd1);
      chk("issue_instr", instruction, data);
      exec_accept               = 1'b1;
      pc_load                   = ld;
      pc_load_value             = ld_val;
      program_counter_increment = inc;
      run                       = run_after;
      @(negedge clk);
      exec_accept = 1'b0;
      if (ld)       exp_pc = ld_val;
      else if (inc) exp_pc = exp_pc + 16'd1;
      chk("next_pc", program_counter, exp_pc);
      chk("next_addr", mem_addr, exp_pc);
      chk("next_valid", 16'(instruction_valid), 16'd0);
      chk("next_req", 16'(mem_req), 16'(run_after));
      if (!run_after) begin
         scramble_ignored();
         run = 1'b0;
         @(negedge clk);
         chk("idle_req", 16'(mem_req), 16'd0);
         chk("idle_pc", program_counter, exp_pc);
         run = 1'b1;
         @(negedge clk);
         chk("rerun_req", 16'(mem_req), 16'd1);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      run = 1'b0;
      mem_ready = 1'b0;
      mem_data = 16'h0000;
      exec_accept = 1'b0;
      program_counter_increment = 1'b0;
      pc_load = 1'b0;
      pc_load_value = 16'h0000;
      exp_pc = RST_PC;
      @(negedge clk);
      @(negedge clk);
      chk("rst_req", 16'(mem_req), 16'd0);
      chk("rst_addr", mem_addr, RST_PC);
      chk("rst_pc", program_counter, RST_PC);
      chk("rst_instr", instruction, 16'h0000);
      chk("rst_valid", 16'(instruction_valid), 16'd0);
      chk("rst_err", 16'(fetch_error), 16'd0);

      reset_n = 1'b1;
      run     = 1'b1;
      @(negedge clk);

      // Zero-wait fetch, then increment.
      fetch_issue(0, 16'h0056, 0, 1'b0, 16'h0000, 1'b1, 1'b1);
      chk("first_inc", mem_addr, 16'h0001);
      // Taken jump.
      fetch_issue(0, 16'hA001, 0, 1'b1, 16'h1234, 1'b0, 1'b1);
      chk("jump", mem_addr, 16'h1234);
      // Load wins over increment.
      fetch_issue(0, 16'hA002, 0, 1'b1, 16'h0010, 1'b0, 1'b1);
      fetch_issue(0, 16'hA003, 0, 1'b1, 16'h0040, 1'b1, 1'b1);
      chk("load_wins", program_counter, 16'h0040);
      // Neither control: same address refetched.
      fetch_issue(0, 16'hA004, 0, 1'b1, 16'h0010, 1'b0, 1'b1);
      fetch_issue(1, 16'hA005, 1, 1'b0, 16'h7777, 1'b0, 1'b1);
      chk("self_loop", mem_addr, 16'h0010);
      // Wrap at 16'hFFFF.
      fetch_issue(0, 16'hA006, 0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
      fetch_issue(0, 16'hA007, 0, 1'b0, 16'h0000, 1'b1, 1'b1);
      chk("wrap", program_counter, 16'h0000);
      // Three wait states, accept held off four cycles.
      fetch_issue(3, 16'hBEEF, 4, 1'b0, 16'h0000, 1'b1, 1'b1);
      // Stop after accept, then restart.
      fetch_issue(2, 16'hC0DE, 1, 1'b1, 16'h0200, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         fetch_issue(int'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 3)),
                     1'($urandom), 16'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) != 0));
      end

`ifndef IFU_MEM_TIMEOUT_EN
      // Without the timeout, a long stall just keeps requesting.
      for (int i = 0; i < 20; i++) begin
         mem_ready = 1'b0;
         @(negedge clk);
         chk("stall_req", 16'(mem_req), 16'd1);
         chk("stall_err", 16'(fetch_error), 16'd0);
      end
      fetch_issue(0, 16'h1111, 0, 1'b0, 16'h0000, 1'b1, 1'b1);
`endif

      // Asynchronous reset in the middle of ISSUE.
      mem_ready = 1'b1;
      mem_data  = 16'h5A5A;
      @(negedge clk);
      mem_ready = 1'b0;
      chk("pre_rst_valid", 16'(instruction_valid), 16'd1);
      #2 reset_n = 1'b0;
      #1;
      exp_pc = RST_PC;
      chk("arst_valid", 16'(instruction_valid), 16'd0);
      chk("arst_pc", program_counter, RST_PC);
      chk("arst_instr", instruction, 16'h0000);
      chk("arst_req", 16'(mem_req), 16'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run     = 1'b1;
      @(negedge clk);
      fetch_issue(1, 16'h0077, 0, 1'b0, 16'h0000, 1'b1, 1'b1);

`ifdef IFU_MEM_TIMEOUT_EN
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("to_wait_req", 16'(mem_req), 16'd1);
         chk("to_wait_err", 16'(fetch_error), 16'd0);
      end
      @(negedge clk);
      chk("to_err", 16'(fetch_error), 16'd1);
      chk("to_req", 16'(mem_req), 16'd0);
      chk("to_pc", program_counter, exp_pc);
      for (int i = 0; i < 5; i++) begin
         mem_ready = 1'b1;
         @(negedge clk);
         chk("to_park_req", 16'(mem_req), 16'd0);
         chk("to_park_err", 16'(fetch_error), 16'd1);
      end
      reset_n = 1'b0;
      #1;
      chk("to_rst_err", 16'(fetch_error), 16'd0);
      @(negedge clk);
      reset_n = 1'b1;
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
